// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among requesters.
// Credit-based occupancy tracking with live level and high-water mark.
module fifo_rr_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  input  logic                          fifo_r_en,
  input  logic                          clr_max,
  output logic [LVL_W-1:0]              level,
  output logic [LVL_W-1:0]              max_level,
  output logic                          overflow_err
);

  localparam int CAP  = DEPTH - 1;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int PW1  = PTR_W + 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W:0]        cand;
  logic                  found;
  logic                  space;
  logic                  inc;
  logic                  dec;
  logic [LVL_W-1:0]      level_nxt;
  logic [DATA_WIDTH-1:0] word;

  assign space = (level < LVL_W'(CAP));
  assign inc   = |gnt;
  assign dec   = fifo_r_en & ~fifo_empty;

  // Search upward from rr_ptr for the first active requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + PW1'(k);
      if (cand >= PW1'(NUM_REQ))
        cand = cand - PW1'(NUM_REQ);
      if (!found && req[cand[PTR_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
    if (found && space && rst_n)
      gnt[gnt_idx] = 1'b1;
  end

  // Select the granted requester's word.
  always_comb begin
    word = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next credited level; a read never drives it below zero.
  always_comb begin
    level_nxt = level;
    if (inc && !dec)
      level_nxt = level + LVL_W'(1);
    else if (!inc && dec && level != '0)
      level_nxt = level - LVL_W'(1);
  end

  // Commit a grant: write strobe, data and pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_w_en    <= 1'b0;
      fifo_data_in <= '0;
      rr_ptr       <= '0;
    end else begin
      fifo_w_en <= inc;
      if (inc) begin
        fifo_data_in <= word;
        if (gnt_idx == PTR_W'(NUM_REQ - 1))
          rr_ptr <= '0;
        else
          rr_ptr <= gnt_idx + PTR_W'(1);
      end
    end
  end

  // Occupancy, high-water mark and sticky error tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level        <= '0;
      max_level    <= '0;
      overflow_err <= 1'b0;
    end else begin
      level <= level_nxt;
      if (clr_max)
        max_level <= level_nxt;
      else if (level_nxt > max_level)
        max_level <= level_nxt;
      if ((fifo_w_en && fifo_full) || (dec && level == '0))
        overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed bench for fifo_rr_write_arbiter.
// A small pointer-based FIFO sits behind the write port.
module tb_fifo_rr_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_w_en;
  logic [7:0]  fifo_data_in;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic        clr_max;
  logic [3:0]  level;
  logic [3:0]  max_level;
  logic        overflow_err;

  logic        force_full;
  logic [7:0]  mem [0:7];
  logic [2:0]  wp;
  logic [2:0]  rp;
  logic        m_full;
  logic        m_empty;

  int total = 0;
  int bad   = 0;

  fifo_rr_write_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .DEPTH(8), .LVL_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .fifo_w_en(fifo_w_en),
    .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_r_en(fifo_r_en),
    .clr_max(clr_max),
    .level(level),
    .max_level(max_level),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_full     = ((wp + 3'd1) == rp);
  assign m_empty    = (wp == rp);
  assign fifo_full  = m_full | force_full;
  assign fifo_empty = m_empty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (fifo_w_en && !m_full) begin
        mem[wp] <= fifo_data_in;
        wp      <= wp + 3'd1;
      end
      if (fifo_r_en && !m_empty)
        rp <= rp + 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rr_g [7];
    logic [7:0] rr_w [7];
    rr_g = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
    rr_w = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10, 8'h21, 8'h32};

    rst_n      = 1'b0;
    req        = 4'hF;
    req_data   = 32'h4332_2110;
    fifo_r_en  = 1'b0;
    clr_max    = 1'b0;
    force_full = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 'h0);
    chk("rst_wen", 32'(fifo_w_en), 'h0);
    chk("rst_lvl", 32'(level), 'h0);
    chk("rst_max", 32'(max_level), 'h0);
    chk("rst_ovf", 32'(overflow_err), 'h0);
    rst_n = 1'b1;
    #1;
    chk("first_gnt", 32'(gnt), 'h1);

    for (int i = 0; i < 7; i++) begin
      chk("rr_gnt", 32'(gnt), 32'(rr_g[i]));
      tick();
      chk("rr_lvl", 32'(level), 32'(i + 1));
      chk("rr_wen", 32'(fifo_w_en), 'h1);
      chk("rr_data", 32'(fifo_data_in), 32'(rr_w[i]));
    end
    chk("cap_gnt", 32'(gnt), 'h0);
    tick();
    chk("cap_full", 32'(fifo_full), 'h1);
    chk("cap_wen", 32'(fifo_w_en), 'h0);
    chk("cap_ovf", 32'(overflow_err), 'h0);
    chk("cap_max", 32'(max_level), 'h7);
    chk("cap_gnt2", 32'(gnt), 'h0);
    for (int i = 0; i < 7; i++)
      chk("fifo_word", 32'(mem[i]), 32'(rr_w[i]));

    req       = 4'b0100;
    fifo_r_en = 1'b1;
    #1;
    chk("rd_cycle_gnt", 32'(gnt), 'h0);
    chk("fifo_head", 32'(mem[rp]), 'h10);
    tick();
    fifo_r_en = 1'b0;
    chk("rd_lvl", 32'(level), 'h6);
    #1;
    chk("after_rd_gnt", 32'(gnt), 'h4);
    tick();
    chk("refill_lvl", 32'(level), 'h7);
    chk("refill_data", 32'(fifo_data_in), 'h32);
    chk("refill_gnt", 32'(gnt), 'h0);

    rst_n = 1'b0;
    req   = 4'b1010;
    #1;
    chk("rst2_lvl", 32'(level), 'h0);
    chk("rst2_wen", 32'(fifo_w_en), 'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("skip_g0", 32'(gnt), 'h2);
    tick();
    chk("skip_d0", 32'(fifo_data_in), 'h21);
    chk("skip_g1", 32'(gnt), 'h8);
    tick();
    chk("skip_d1", 32'(fifo_data_in), 'h43);
    chk("skip_g2", 32'(gnt), 'h2);
    tick();
    chk("skip_d2", 32'(fifo_data_in), 'h21);
    chk("skip_lvl", 32'(level), 'h3);
    chk("skip_g3", 32'(gnt), 'h8);

    fifo_r_en = 1'b1;
    tick();
    fifo_r_en = 1'b0;
    chk("same_lvl", 32'(level), 'h3);
    chk("same_max", 32'(max_level), 'h3);
    chk("same_data", 32'(fifo_data_in), 'h43);

    req = 4'b1011;
    #1;
    chk("req0_gnt", 32'(gnt), 'h1);
    tick();
    chk("req0_data", 32'(fifo_data_in), 'h10);
    chk("req0_lvl", 32'(level), 'h4);
    chk("next_gnt", 32'(gnt), 'h2);
    tick();
    chk("hw_lvl5", 32'(level), 'h5);

    req       = 4'b0000;
    fifo_r_en = 1'b1;
    tick();
    tick();
    tick();
    fifo_r_en = 1'b0;
    chk("drain_lvl", 32'(level), 'h2);
    chk("drain_max", 32'(max_level), 'h5);
    clr_max = 1'b1;
    tick();
    clr_max = 1'b0;
    chk("clr_max", 32'(max_level), 'h2);
    chk("clr_lvl", 32'(level), 'h2);

    req = 4'b0001;
    #1;
    chk("ovf_gnt", 32'(gnt), 'h1);
    tick();
    req = 4'b0000;
    chk("ovf_wen", 32'(fifo_w_en), 'h1);
    chk("ovf_pre", 32'(overflow_err), 'h0);
    force_full = 1'b1;
    tick();
    force_full = 1'b0;
    chk("ovf_set", 32'(overflow_err), 'h1);
    tick();
    tick();
    chk("ovf_sticky", 32'(overflow_err), 'h1);
    rst_n = 1'b0;
    #1;
    chk("ovf_rst", 32'(overflow_err), 'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
